// File: rtl/regfile_bypass_if.sv
// regfile_bypass_if: register-file access bundle (one WB write port, two ID read ports)
//   master: write strobe/index/data and both read indices out, read data in
//   slave : the register file side
interface regfile_bypass_if #(parameter int WIDTH = 64);
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;
  modport master (output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
                  input  ReadData1, ReadData2);
  modport slave  (input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
                  output ReadData1, ReadData2);
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass: 32 x WIDTH LEGv8 register file, two combinational reads, one synchronous write
//   clk   : write clock (rising edge)
//   reset : asynchronous active-high clear of every register
//   bus   : slave side of regfile_bypass_if (RegWrite/WriteRegister/WriteData in,
//           ReadRegister1/2 in, ReadData1/2 out)
module regfile_bypass #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic reset,
  regfile_bypass_if.slave bus
);
  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] wren;
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    assign wren[g] = bus.RegWrite && bus.WriteRegister == 5'(g) && g != ZERO_REG;
    always_ff @(posedge clk or posedge reset)
      if (reset) regs[g] <= '0;
      else if (wren[g]) regs[g] <= bus.WriteData;
  end
  // Forwarding is suppressed during reset: that write is discarded, so the file must read zero.
  logic byp1, byp2;
  assign byp1 = BYPASS != 0 && !reset && wren[bus.ReadRegister1];
  assign byp2 = BYPASS != 0 && !reset && wren[bus.ReadRegister2];
  assign bus.ReadData1 = bus.ReadRegister1 == 5'(ZERO_REG) ? '0 : byp1 ? bus.WriteData : regs[bus.ReadRegister1];
  assign bus.ReadData2 = bus.ReadRegister2 == 5'(ZERO_REG) ? '0 : byp2 ? bus.WriteData : regs[bus.ReadRegister2];
endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass: checks bypassing and non-bypassing register files against an array model
module tb_regfile_bypass;
  logic clk = 0;
  logic reset = 1;
  logic we = 0;
  logic [4:0] wa = 0, ra1 = 0, ra2 = 0;
  logic [63:0] wd = 0;
  int checks = 0, errors = 0;
  logic [63:0] mem [32];
  always #5 clk = ~clk;
  regfile_bypass_if #(.WIDTH(64)) ib ();
  regfile_bypass_if #(.WIDTH(64)) in ();
  assign ib.RegWrite = we;
  assign ib.WriteRegister = wa;
  assign ib.WriteData = wd;
  assign ib.ReadRegister1 = ra1;
  assign ib.ReadRegister2 = ra2;
  assign in.RegWrite = we;
  assign in.WriteRegister = wa;
  assign in.WriteData = wd;
  assign in.ReadRegister1 = ra1;
  assign in.ReadRegister2 = ra2;
  regfile_bypass #(.BYPASS(1)) dut_b (.clk(clk), .reset(reset), .bus(ib));
  regfile_bypass #(.BYPASS(0)) dut_n (.clk(clk), .reset(reset), .bus(in));
  always @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < 32; i++) mem[i] = 0;
    else if (we && wa != 31) mem[wa] = wd;
  function automatic logic [63:0] model(logic [4:0] idx, bit bp);
    if (idx == 31) return 0;
    if (bp && !reset && we && wa == idx) return wd;
    return mem[idx];
  endfunction
  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("cmp_b_rd1", ib.ReadData1, model(ra1, 1));
    chk("cmp_b_rd2", ib.ReadData2, model(ra2, 1));
    chk("cmp_n_rd1", in.ReadData1, model(ra1, 0));
    chk("cmp_n_rd2", in.ReadData2, model(ra2, 0));
  end
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  task automatic lit(string name, logic [63:0] eb1, logic [63:0] eb2, logic [63:0] en1, logic [63:0] en2);
    #1;
    chk({name, "_b1"}, ib.ReadData1, eb1);
    chk({name, "_b2"}, ib.ReadData2, eb2);
    chk({name, "_n1"}, in.ReadData1, en1);
    chk({name, "_n2"}, in.ReadData2, en2);
  endtask
  initial begin
    go();
    go();
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      chk("reset_zero_b1", ib.ReadData1, 0);
      chk("reset_zero_b2", ib.ReadData2, 0);
      chk("reset_zero_n1", in.ReadData1, 0);
      chk("reset_zero_n2", in.ReadData2, 0);
    end
    go();
    we = 1; wa = 5; wd = 64'hDEAD_BEEF_0123_4567;
    go();
    we = 0; ra1 = 5; ra2 = 5;
    lit("x5", 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
    ra1 = 4; ra2 = 6;
    lit("x4x6", 0, 0, 0, 0);
    go();
    we = 1; wa = 31; wd = '1; ra1 = 31; ra2 = 5;
    lit("x31_during", 0, 64'hDEAD_BEEF_0123_4567, 0, 64'hDEAD_BEEF_0123_4567);
    go();
    we = 0;
    lit("x31_after", 0, 64'hDEAD_BEEF_0123_4567, 0, 64'hDEAD_BEEF_0123_4567);
    go();
    we = 1; wa = 7; wd = 64'h1234; ra1 = 7; ra2 = 31;
    lit("byp_before", 64'h1234, 0, 0, 0);
    go();
    we = 0;
    lit("byp_after", 64'h1234, 0, 64'h1234, 0);
    go();
    we = 1; wa = 3; wd = 64'hAA;
    go();
    we = 0; wd = 64'hBB;
    repeat (3) go();
    wa = 5'bx; ra1 = 3; ra2 = 7;
    go();
    lit("hold_x3", 64'hAA, 64'h1234, 64'hAA, 64'h1234);
    wa = 0;
    we = 1; wa = 1; wd = 64'h55;
    go();
    wa = 2; wd = 64'h66;
    go();
    we = 0; ra1 = 1; ra2 = 2;
    lit("x1x2", 64'h55, 64'h66, 64'h55, 64'h66);
    reset = 1;
    lit("async_rst", 0, 0, 0, 0);
    we = 1; wa = 2; wd = 64'h99;
    go();
    reset = 0; wa = 1; wd = 64'h77;
    go();
    we = 0;
    lit("post_rst", 64'h77, 0, 64'h77, 0);
    for (int n = 0; n < 500; n++) begin
      go();
      reset = $urandom_range(0, 59) == 0;
      we = $urandom_range(0, 1) == 1;
      wa = $urandom_range(0, 4) == 0 ? 5'd31 : 5'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      ra1 = $urandom_range(0, 2) == 0 ? wa : 5'($urandom_range(0, 7)) | ($urandom_range(0, 9) == 0 ? 5'd31 : 5'd0);
      ra2 = $urandom_range(0, 2) == 0 ? wa : 5'($urandom_range(0, 7));
    end
    go();
    reset = 0; we = 0;
    go();
    go();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_bypass.md
Name: regfile_bypass

Overview:
- 32-entry × 64-bit LEGv8 architectural register file.
- Storage is built from per-bit enabled flip-flops; a 5→32 write decoder drives each register's write enable.
- Two combinational read ports feed the ID stage; one synchronous write port is driven from WB.
- Optional write-to-read bypass resolves the WB→ID same-cycle hazard without a half-cycle write.

Parameters:
- WIDTH, 64, data width of each register.
- NREGS, 32, number of registers; address width is fixed at 5 bits.
- ZERO_REG, 31, index of XZR; it always reads 0 and ignores writes.
- BYPASS, 1, when 1 the read ports forward same-cycle write data; when 0 they return stored contents only.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- RegWrite  input  1  write strobe from WB.
- WriteRegister  input  5  destination register index.
- WriteData  input  WIDTH  data to write.
- ReadRegister1  input  5  read port 1 index (Rn).
- ReadRegister2  input  5  read port 2 index (Rm/Rt).
- ReadData1  output  WIDTH  read port 1 data.
- ReadData2  output  WIDTH  read port 2 data.

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset:
  - Assertion immediately forces all 32 registers to 0, regardless of clk.
  - ReadDataN therefore reads 0 for every index while reset is high, and after release until each register is written.
  - A write whose edge coincides with reset high is discarded.
- Write decode:
  - wren[i] = RegWrite & (WriteRegister == i) & (i != ZERO_REG).
  - At most one wren bit is high at any time.
  - Registers with wren low hold their value.
- Write timing:
  - Register i captures WriteData on the rising clk edge when wren[i] = 1.
  - Stored value is visible on ReadDataN (BYPASS=0 path) after that edge: 1-cycle write latency.
- Read path:
  - Purely combinational 32:1 mux per port; no read latency.
  - ReadDataN is 0 whenever ReadRegisterN == ZERO_REG, overriding storage and bypass.
- Bypass (BYPASS=1):
  - Condition: RegWrite = 1, WriteRegister == ReadRegisterN, and WriteRegister != ZERO_REG.
  - When the condition holds, ReadDataN = WriteData in the same cycle, before the edge.
  - Each port evaluates the condition independently; both ports may bypass at once.
- BYPASS=0: ReadDataN reflects stored contents only; same-cycle reads return the old value.
- Simultaneous read and write of the same index with BYPASS=1: ReadDataN = new WriteData before and after the edge, with no glitch back to the old value once inputs are stable.
- Writes to register 31 are dropped silently; no state change and no bypass.
- X/unknown WriteRegister with RegWrite = 0 must not corrupt any register.
- Reset mid-operation:
  - All contents are lost and the register file reads all zeros.
  - The first write after reset release takes effect on the first rising edge with reset low.

Test Plan:
1. Reset, then read all 32 indices on both ports → every ReadDataN = 64'h0.
2. Write X5 = 64'hDEAD_BEEF_0123_4567 with RegWrite=1 for one edge; next cycle ReadRegister1=5, ReadRegister2=5 → both = 64'hDEAD_BEEF_0123_4567. Registers 4 and 6 still read 0.
3. Write X31 = 64'hFFFF_FFFF_FFFF_FFFF → ReadData1 for index 31 = 0, both during the write cycle and after; no other register changes.
4. BYPASS=1: RegWrite=1, WriteRegister=7, WriteData=64'h1234 with ReadRegister1=7 in the same cycle → ReadData1 = 64'h1234 before the edge. With BYPASS=0, the same stimulus → ReadData1 = old value (0) until after the edge.
5. Write X3 = 64'hAA, then set RegWrite=0 with WriteRegister=3, WriteData=64'hBB for 3 edges → X3 stays 64'hAA.
6. Load X1 = 64'h55 and X2 = 64'h66, then assert reset between clock edges → ReadData1 (idx 1) and ReadData2 (idx 2) drop to 0 immediately. After release, a write X1 = 64'h77 → reads 64'h77.
